fetch_queue: RTL

- Parametrised successor to the single-register fetch stage.
- Decouples PC generation from instruction ROM latency using a request/response ROM port, up to DEPTH outstanding fetches, and an in-order slot buffer toward decode.
- Sits between the instruction ROM and decode; accepts redirects from the branch-resolving stage and flushes wrong-path fetches.
- Decode consumes entries through a valid/ready handshake, so stalls no longer drop instructions.

---
 rtl/fetch_queue_pkg.sv | 20 ++
 rtl/fetch_queue_if.sv | 31 +++
 rtl/fetch_queue_slot_buffer.sv | 118 +++++++++++
 rtl/fetch_queue.sv | 105 ++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared fetch-stage types and constants: slot record, PC step, NOP encoding
// and the PC alignment helper used on redirect targets.
package fetch_queue_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'h0000_0004;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_slot_t;

  // Instructions are word aligned; the low two address bits carry no meaning.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: redirect input, request/response ROM port and the
// valid/ready decode port. master = fetch queue, slave = its environment.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);

  logic                   redirect;
  logic [XLEN-1:0]        redirect_target;
  logic                   rom_req;
  logic [XLEN-1:0]        rom_addr;
  logic                   rom_ready;
  logic                   rom_rvalid;
  logic [XLEN-1:0]        rom_rdata;
  logic                   out_valid;
  logic                   out_ready;
  logic [XLEN-1:0]        out_pc;
  logic [XLEN-1:0]        out_instr;
  logic [$clog2(DEPTH):0] occupancy;

  modport master (
    input  redirect, redirect_target, rom_ready, rom_rvalid, rom_rdata, out_ready,
    output rom_req, rom_addr, out_valid, out_pc, out_instr, occupancy
  );

  modport slave (
    output redirect, redirect_target, rom_ready, rom_rvalid, rom_rdata, out_ready,
    input  rom_req, rom_addr, out_valid, out_pc, out_instr, occupancy
  );

endinterface

// File: rtl/fetch_queue_slot_buffer.sv
// Circular in-order slot buffer: slots are allocated at the tail, filled in
// request order through the fill pointer and retired from the head.
module fetch_slot_buffer
  import fetch_queue_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   alloc,
  input  logic [XLEN-1:0]        alloc_pc,
  input  logic                   fill,
  input  logic [XLEN-1:0]        fill_data,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   out_valid,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_instr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [XLEN-1:0]  pc_r    [DEPTH];
  logic [XLEN-1:0]  instr_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W-1:0] fill_r;
  logic [OCC_W-1:0] count_r;
  logic [OCC_W-1:0] pend_r;
  logic             out_valid_r;
  logic [XLEN-1:0]  out_pc_r;
  logic [XLEN-1:0]  out_instr_r;

  logic             fill_ok_s;
  logic             pop_ok_s;
  logic [PTR_W-1:0] head_nxt_s;
  logic [OCC_W-1:0] count_nxt_s;
  logic [OCC_W-1:0] pend_nxt_s;
  logic             valid_nxt_s;
  logic [XLEN-1:0]  head_instr_nxt_s;

  // Next-state view of the head: filled slots always form the oldest prefix,
  // so the head is ready exactly when allocated slots outnumber pending ones.
  always_comb begin
    fill_ok_s  = fill && (pend_r != {OCC_W{1'b0}});
    pop_ok_s   = pop && out_valid_r;
    head_nxt_s = pop_ok_s ? (head_r + PTR_W'(1)) : head_r;
    if (flush) begin
      count_nxt_s = {OCC_W{1'b0}};
      pend_nxt_s  = {OCC_W{1'b0}};
      valid_nxt_s = 1'b0;
    end else begin
      count_nxt_s = count_r + {{(OCC_W-1){1'b0}}, alloc} - {{(OCC_W-1){1'b0}}, pop_ok_s};
      pend_nxt_s  = pend_r + {{(OCC_W-1){1'b0}}, alloc} - {{(OCC_W-1){1'b0}}, fill_ok_s};
      valid_nxt_s = (count_nxt_s > pend_nxt_s);
    end
    if (fill_ok_s && (fill_r == head_nxt_s)) begin
      head_instr_nxt_s = fill_data;
    end else begin
      head_instr_nxt_s = instr_r[head_nxt_s];
    end
  end

  // Slot storage, pointers, counters and the registered head view.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_r[i]    <= {XLEN{1'b0}};
        instr_r[i] <= {XLEN{1'b0}};
      end
      head_r      <= {PTR_W{1'b0}};
      tail_r      <= {PTR_W{1'b0}};
      fill_r      <= {PTR_W{1'b0}};
      count_r     <= {OCC_W{1'b0}};
      pend_r      <= {OCC_W{1'b0}};
      out_valid_r <= 1'b0;
      out_pc_r    <= {XLEN{1'b0}};
      out_instr_r <= {XLEN{1'b0}};
    end else begin
      count_r     <= count_nxt_s;
      pend_r      <= pend_nxt_s;
      out_valid_r <= valid_nxt_s;
      // Empty or flushed: the head view keeps its last contents.
      if (valid_nxt_s) begin
        out_pc_r    <= pc_r[head_nxt_s];
        out_instr_r <= head_instr_nxt_s;
      end
      if (flush) begin
        head_r <= {PTR_W{1'b0}};
        tail_r <= {PTR_W{1'b0}};
        fill_r <= {PTR_W{1'b0}};
      end else begin
        if (alloc) begin
          pc_r[tail_r] <= alloc_pc;
          tail_r       <= tail_r + PTR_W'(1);
        end
        if (fill_ok_s) begin
          instr_r[fill_r] <= fill_data;
          fill_r          <= fill_r + PTR_W'(1);
        end
        if (pop_ok_s) begin
          head_r <= head_nxt_s;
        end
      end
    end
  end

  assign occupancy = count_r;
  assign pending   = pend_r;
  assign out_valid = out_valid_r;
  assign out_pc    = out_pc_r;
  assign out_instr = out_instr_r;

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue top: PC register, ROM request issue, wrong-path discard
// counting on redirect, and the in-order slot buffer toward decode.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input logic         clk,
  input logic         rst,
  fetch_queue_if.master bus
);

  localparam int OCC_W  = $clog2(DEPTH) + 1;
  // Repeated redirects can stack several generations of wrong-path fetches.
  localparam int DISC_W = OCC_W + 3;

  logic [XLEN-1:0]   pc_r;
  logic [DISC_W-1:0] discard_r;
  logic              run_r;

  logic [OCC_W-1:0]  occupancy_s;
  logic [OCC_W-1:0]  pending_s;
  logic              out_valid_s;
  logic [XLEN-1:0]   out_pc_s;
  logic [XLEN-1:0]   out_instr_s;
  logic              rom_req_s;
  logic              issue_s;
  logic              drop_s;
  logic              fill_s;
  logic              pop_s;
  logic [DISC_W-1:0] disc_sum_s;
  logic [DISC_W-1:0] discard_nxt_s;

  // Issue, response routing and discard bookkeeping; redirect overrides all.
  always_comb begin
    if (run_r && !bus.redirect && (occupancy_s < OCC_W'(DEPTH))) begin
      rom_req_s = 1'b1;
    end else begin
      rom_req_s = 1'b0;
    end
    issue_s    = rom_req_s && bus.rom_ready;
    drop_s     = bus.rom_rvalid && (discard_r != {DISC_W{1'b0}});
    fill_s     = bus.rom_rvalid && (discard_r == {DISC_W{1'b0}}) && !bus.redirect;
    pop_s      = out_valid_s && bus.out_ready && !bus.redirect;
    disc_sum_s = discard_r + DISC_W'(pending_s);
    if (bus.redirect) begin
      // Every pending slot becomes wrong-path; a response landing now retires one.
      if (bus.rom_rvalid && (disc_sum_s != {DISC_W{1'b0}})) begin
        discard_nxt_s = disc_sum_s - DISC_W'(1);
      end else begin
        discard_nxt_s = disc_sum_s;
      end
    end else if (drop_s) begin
      discard_nxt_s = discard_r - DISC_W'(1);
    end else begin
      discard_nxt_s = discard_r;
    end
  end

  // PC, discard counter and the post-reset run flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_r      <= RESET_PC;
      discard_r <= {DISC_W{1'b0}};
      run_r     <= 1'b0;
    end else begin
      run_r     <= 1'b1;
      discard_r <= discard_nxt_s;
      if (bus.redirect) begin
        pc_r <= align_pc(bus.redirect_target);
      end else if (issue_s) begin
        pc_r <= pc_r + XLEN'(PC_STEP);
      end
    end
  end

  fetch_slot_buffer #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_slots (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect),
    .alloc     (issue_s),
    .alloc_pc  (pc_r),
    .fill      (fill_s),
    .fill_data (bus.rom_rdata),
    .pop       (pop_s),
    .occupancy (occupancy_s),
    .pending   (pending_s),
    .out_valid (out_valid_s),
    .out_pc    (out_pc_s),
    .out_instr (out_instr_s)
  );

  assign bus.rom_req   = rom_req_s;
  assign bus.rom_addr  = pc_r;
  assign bus.out_valid = out_valid_s;
  assign bus.out_pc    = out_pc_s;
  assign bus.out_instr = out_instr_s;
  assign bus.occupancy = occupancy_s;

endmodule
